// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch buffer: issues sequential word fetches and queues returned
// instructions with their PCs; a redirect flushes the queue and drops in-flight data.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  logic [31:0] fetchPcQ, fetchPcD;
  logic [31:0] respPcQ, respPcD;
  ptr_t        rdPtrQ, rdPtrD;
  ptr_t        wrPtrQ, wrPtrD;
  cnt_t        countQ, countD;
  cnt_t        outstandingQ, outstandingD;
  cnt_t        discardQ, discardD;
  logic [31:0] qInstr [DEPTH];
  logic [31:0] qPc    [DEPTH];

  logic        grant;
  logic        respOk;
  logic        push;
  logic        pop;
  logic [CntW:0] inFlight;
  logic [31:0] redirAligned;
  logic        unusedRedirLow;

  assign unusedRedirLow = ^redirect_pc[1:0];
  assign redirAligned   = {redirect_pc[31:2], 2'b00};

  // Queued plus outstanding is capped at DEPTH, so a push never meets a full queue.
  assign inFlight = {1'b0, countQ} + {1'b0, outstandingQ};
  assign mem_req  = !rst && !redirect_valid && (inFlight < (CntW + 1)'(DEPTH));
  assign mem_addr = fetchPcQ;

  assign instr_valid = (countQ != '0);
  assign instr       = instr_valid ? qInstr[rdPtrQ] : '0;
  assign instr_pc    = instr_valid ? qPc[rdPtrQ] : '0;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign grant  = mem_req && mem_gnt;
  assign respOk = mem_rvalid && (outstandingQ != '0);
  assign push   = respOk && (discardQ == '0) && !redirect_valid;
  assign pop    = instr_valid && !stall && !redirect_valid;

  always_comb begin
    fetchPcD     = fetchPcQ;
    respPcD      = respPcQ;
    rdPtrD       = rdPtrQ;
    wrPtrD       = wrPtrQ;
    countD       = countQ;
    outstandingD = outstandingQ - cnt_t'(respOk);
    discardD     = discardQ;
    if (redirect_valid) begin
      fetchPcD = redirAligned;
      respPcD  = redirAligned;
      rdPtrD   = '0;
      wrPtrD   = '0;
      countD   = '0;
      // Everything still unanswered after this edge was issued before the redirect.
      discardD = outstandingQ - cnt_t'(respOk);
    end else begin
      if (grant) begin
        fetchPcD     = fetchPcQ + 32'd4;
        outstandingD = outstandingQ + cnt_t'(1'b1) - cnt_t'(respOk);
      end
      if (respOk && (discardQ != '0)) begin
        discardD = discardQ - cnt_t'(1'b1);
      end
      if (push) begin
        wrPtrD  = wrPtrQ + ptr_t'(1);
        respPcD = respPcQ + 32'd4;
      end
      if (pop) begin
        rdPtrD = rdPtrQ + ptr_t'(1);
      end
      countD = countQ + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPcQ     <= RESET_PC;
      respPcQ      <= RESET_PC;
      rdPtrQ       <= '0;
      wrPtrQ       <= '0;
      countQ       <= '0;
      outstandingQ <= '0;
      discardQ     <= '0;
    end else begin
      fetchPcQ     <= fetchPcD;
      respPcQ      <= respPcD;
      rdPtrQ       <= rdPtrD;
      wrPtrQ       <= wrPtrD;
      countQ       <= countD;
      outstandingQ <= outstandingD;
      discardQ     <= discardD;
    end
  end

  // Storage needs no reset: outputs are gated by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      qInstr[wrPtrQ] <= mem_rdata;
      qPc[wrPtrQ]    <= respPcQ;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: in-order memory model with epoch-tagged
// requests, a queue-based reference of the instruction stream, directed and random phases.
module tb_instr_prefetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    int unsigned lat;
    int unsigned pre;
    logic [31:0] rpc;
    logic [31:0] expPc;
  } redir_vec_t;

  pend_t       pending[$];   // granted requests the memory has not answered yet
  ent_t        mq[$];        // instructions the fetch stage should see, head first
  int unsigned epoch;
  int unsigned edgeCnt;
  logic [31:0] nextAddr;
  logic [31:0] dataKey;
  int unsigned latency;
  int unsigned gntPct;
  int unsigned rvPct;
  int          nTests;
  int          nFail;

  logic        sValid;
  logic        sReq;
  logic [31:0] sInstr;
  logic [31:0] sPc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare all outputs against the
  // reference, then advance the reference across the rising edge.
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic stl,
                       input logic spurious);
    logic        rv;
    logic        expReq;
    logic        expValid;
    logic        grant;
    logic        keep;
    logic [31:0] gAddr;
    pend_t       p;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    stall          = stl;
    mem_gnt        = ($urandom_range(99) < gntPct);
    rv = (pending.size() != 0) && (pending[0].due <= edgeCnt + 1) &&
         ($urandom_range(99) < rvPct);
    if (spurious && pending.size() == 0) rv = 1'b1;
    mem_rvalid = rv;
    mem_rdata  = (rv && pending.size() != 0) ? (pending[0].addr ^ dataKey) : $urandom;
    #1;
    expReq   = !redir && (mq.size() + pending.size() < DEPTH);
    expValid = (mq.size() != 0);
    sValid = instr_valid;
    sReq   = mem_req;
    sInstr = instr;
    sPc    = instr_pc;
    check("instr_valid", {31'b0, instr_valid}, {31'b0, expValid});
    check("instr", instr, expValid ? mq[0].instr : 32'h0);
    check("instr_pc", instr_pc, expValid ? mq[0].pc : 32'h0);
    check("mem_req", {31'b0, mem_req}, {31'b0, expReq});
    if (expReq) check("mem_addr", mem_addr, nextAddr);
    grant = expReq && mem_gnt;
    gAddr = nextAddr;
    @(posedge clk);
    edgeCnt++;
    keep = 1'b0;
    p    = '{addr: 32'h0, epoch: 0, due: 0};
    if (rv && pending.size() != 0) begin
      p    = pending.pop_front();
      keep = (p.epoch == epoch);
    end
    if (redir) begin
      mq.delete();
      epoch++;
      nextAddr = {rpc[31:2], 2'b00};
    end else begin
      if (mq.size() != 0 && !stl) void'(mq.pop_front());
      if (keep) mq.push_back('{instr: p.addr ^ dataKey, pc: p.addr});
    end
    if (grant) begin
      pending.push_back('{addr: gAddr, epoch: epoch, due: edgeCnt + latency});
      nextAddr = gAddr + 32'd4;
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_pc"}, instr_pc, 32'h0);
    check({tag, "_req"}, {31'b0, mem_req}, 32'h0);
    check({tag, "_addr"}, mem_addr, RESET_PC);
  endtask

  // Asserts reset immediately (asynchronously), holds it across two edges, releases it.
  task automatic resetPhase(input string tag);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'h0;
    mq.delete();
    pending.delete();
    epoch++;
    nextAddr = RESET_PC;
    #1;
    checkReset(tag);
    repeat (2) begin
      @(posedge clk);
      edgeCnt++;
    end
    #1;
    checkReset({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_first_req"}, {31'b0, mem_req}, 32'h1);
    check({tag, "_first_addr"}, mem_addr, RESET_PC);
    check({tag, "_empty"}, {31'b0, instr_valid}, 32'h0);
    @(posedge clk);
    edgeCnt++;
  endtask

  initial begin
    redir_vec_t vecs[4];
    int         validRun;
    logic       found;

    vecs[0] = '{lat: 3, pre: 6, rpc: 32'h0000_0103, expPc: 32'h0000_0100};
    vecs[1] = '{lat: 1, pre: 5, rpc: 32'h0000_2002, expPc: 32'h0000_2000};
    vecs[2] = '{lat: 2, pre: 3, rpc: 32'hFFFF_FFF8, expPc: 32'hFFFF_FFF8};
    vecs[3] = '{lat: 4, pre: 2, rpc: 32'h0000_0047, expPc: 32'h0000_0044};

    nTests   = 0;
    nFail    = 0;
    epoch    = 0;
    edgeCnt  = 0;
    dataKey  = 32'h0;
    latency  = 1;
    gntPct   = 100;
    rvPct    = 100;
    nextAddr = RESET_PC;
    sValid   = 1'b0;
    sReq     = 1'b0;
    sInstr   = 32'h0;
    sPc      = 32'h0;

    resetPhase("por");

    // Single-cycle memory: after fill, one instruction per cycle with no gaps.
    validRun = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      if (i == 2) check("first_pc", sPc, 32'h0);
      if (i >= 8 && sValid) validRun++;
    end
    check("throughput", validRun, 12);

    // Stall until the queue is full and nothing is outstanding.
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("stall_full_req", {31'b0, sReq}, 32'h0);
    check("stall_full_valid", {31'b0, sValid}, 32'h1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Redirect vectors: first kept instruction must come from the aligned new PC.
    for (int v = 0; v < 4; v++) begin
      latency = vecs[v].lat;
      for (int i = 0; i < int'(vecs[v].pre); i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, vecs[v].rpc, 1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        found = sValid;
      end
      check("redir_found", {31'b0, found}, 32'h1);
      check("redir_first_pc", sPc, vecs[v].expPc);
      check("redir_first_instr", sInstr, vecs[v].expPc);
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end

    // Reset mid-stream with requests in flight.
    latency = 2;
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    edgeCnt++;
    #2;
    resetPhase("mid");
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Randomised traffic against the reference.
    dataKey = $urandom;
    for (int blk = 0; blk < 6; blk++) begin
      latency = $urandom_range(5, 1);
      gntPct  = $urandom_range(100, 30);
      rvPct   = $urandom_range(100, 40);
      for (int i = 0; i < 500; i++) begin
        cycle(($urandom_range(99) < 3), $urandom, ($urandom_range(99) < 25),
              ($urandom_range(99) < 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
